falu_seq: RTL and testbench

- Parametrised, multi-cycle successor to the combinational 16-bit FP ALU.
- Performs add, sub, mul and div on IEEE-754-style operands of configurable exponent/mantissa width.
- Uses a valid/ready handshake on both sides, an iterative divider and IEEE exception flags.
- Sits between the operand register file and the result writeback stage; one operation in flight at a time.

---
 rtl/falu_seq.sv | 349 ++++++++++++++++++++++++++++++++++
 tb/tb_falu_seq.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/falu_seq.sv
// falu_seq: multi-cycle floating-point add/sub/mul/div with valid/ready handshakes.
// One operation in flight; flush-to-zero on inputs and results; round toward zero.
module falu_seq #(
    parameter int unsigned EXP_W = 5,
    parameter int unsigned MAN_W = 10
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [EXP_W+MAN_W:0] a,
    input  logic [EXP_W+MAN_W:0] b,
    input  logic [1:0]           op,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [EXP_W+MAN_W:0] result,
    output logic [3:0]           flags
);

    localparam int unsigned W     = 1 + EXP_W + MAN_W;
    localparam int unsigned AW    = MAN_W + 3;       // carry, hidden, fraction, guard
    localparam int unsigned QW    = MAN_W + 2;       // quotient bits / divider iterations
    localparam int unsigned NW    = 2 * MAN_W + 2;   // normaliser width (full product)
    localparam int unsigned E2    = EXP_W + 2;       // signed exponent width, no wrap
    localparam int unsigned LZ_W  = $clog2(NW + 1);
    localparam int unsigned CNT_W = $clog2(QW + 1);

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    localparam logic [W-1:0] QNAN =
        {1'b0, {EXP_W{1'b1}}, {MAN_W{1'b0}}} | (W'(1) << (MAN_W - 1));
    localparam logic signed [E2-1:0] BIAS    = E2'((1 << (EXP_W - 1)) - 1);
    localparam logic signed [E2-1:0] EXP_MAX = E2'((1 << EXP_W) - 1);

    // flag bit positions
    localparam int unsigned F_INV = 3;
    localparam int unsigned F_DBZ = 2;
    localparam int unsigned F_OVF = 1;
    localparam int unsigned F_UNF = 0;

    typedef enum logic [2:0] {StIdle, StUnpack, StExec, StNorm, StDone} state_e;

    function automatic logic [W-1:0] inf_of(input logic s);
        return {s, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    endfunction

    function automatic logic [W-1:0] zero_of(input logic s);
        return {s, {(W - 1){1'b0}}};
    endfunction

    state_e                state_q;
    logic [W-1:0]          a_q, b_q;
    logic [1:0]            op_q;
    logic                  sa_q, sb_q, sp_q;
    logic [EXP_W-1:0]      ea_q, eb_q;
    logic [MAN_W:0]        ma_q, mb_q;
    logic                  spec_q;
    logic [W-1:0]          spec_res_q;
    logic [3:0]            spec_flags_q;
    logic [NW-1:0]         man_q;
    logic signed [E2-1:0]  exp_q;
    logic                  sign_q;
    logic [QW-1:0]         rem_q, quo_q;
    logic [CNT_W-1:0]      cnt_q;

    // ------------------------------------------------------------------
    // Unpack: field split, hidden bit, flush of subnormals, classification
    // ------------------------------------------------------------------
    logic [EXP_W-1:0] a_exp, b_exp;
    logic [MAN_W-1:0] a_frac, b_frac;
    logic             a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, a_snan, b_snan;
    logic [MAN_W:0]   u_ma, u_mb;
    logic             u_sa, u_sb, u_sp;

    assign a_exp  = a_q[W-2 -: EXP_W];
    assign b_exp  = b_q[W-2 -: EXP_W];
    assign a_frac = a_q[MAN_W-1:0];
    assign b_frac = b_q[MAN_W-1:0];

    // exponent field zero covers both true zero and subnormals (flushed)
    assign a_zero = (a_exp == '0);
    assign b_zero = (b_exp == '0);
    assign a_inf  = (a_exp == '1) && (a_frac == '0);
    assign b_inf  = (b_exp == '1) && (b_frac == '0);
    assign a_nan  = (a_exp == '1) && (a_frac != '0);
    assign b_nan  = (b_exp == '1) && (b_frac != '0);
    assign a_snan = a_nan && !a_frac[MAN_W-1];
    assign b_snan = b_nan && !b_frac[MAN_W-1];

    assign u_ma = a_zero ? '0 : {1'b1, a_frac};
    assign u_mb = b_zero ? '0 : {1'b1, b_frac};
    assign u_sa = a_q[W-1];
    // subtraction is addition of the negated b
    assign u_sb = b_q[W-1] ^ (op_q == OP_SUB);
    assign u_sp = a_q[W-1] ^ b_q[W-1];

    logic             u_spec;
    logic [W-1:0]     u_spec_res;
    logic [3:0]       u_spec_flags;

    // Special-operand classification; these results bypass the arithmetic
    always_comb begin
        u_spec       = 1'b0;
        u_spec_res   = '0;
        u_spec_flags = '0;
        if (a_nan || b_nan) begin
            u_spec              = 1'b1;
            u_spec_res          = QNAN;
            u_spec_flags[F_INV] = a_snan || b_snan;
        end else begin
            unique case (op_q)
                OP_ADD, OP_SUB: begin
                    if (a_inf && b_inf) begin
                        u_spec = 1'b1;
                        if (u_sa != u_sb) begin
                            u_spec_res          = QNAN;
                            u_spec_flags[F_INV] = 1'b1;
                        end else begin
                            u_spec_res = inf_of(u_sa);
                        end
                    end else if (a_inf) begin
                        u_spec     = 1'b1;
                        u_spec_res = inf_of(u_sa);
                    end else if (b_inf) begin
                        u_spec     = 1'b1;
                        u_spec_res = inf_of(u_sb);
                    end
                end
                OP_MUL: begin
                    if ((a_inf && b_zero) || (a_zero && b_inf)) begin
                        u_spec              = 1'b1;
                        u_spec_res          = QNAN;
                        u_spec_flags[F_INV] = 1'b1;
                    end else if (a_inf || b_inf) begin
                        u_spec     = 1'b1;
                        u_spec_res = inf_of(u_sp);
                    end else if (a_zero || b_zero) begin
                        u_spec     = 1'b1;
                        u_spec_res = zero_of(u_sp);
                    end
                end
                OP_DIV: begin
                    if ((a_zero && b_zero) || (a_inf && b_inf)) begin
                        u_spec              = 1'b1;
                        u_spec_res          = QNAN;
                        u_spec_flags[F_INV] = 1'b1;
                    end else if (a_inf) begin
                        u_spec     = 1'b1;
                        u_spec_res = inf_of(u_sp);
                    end else if (b_inf) begin
                        u_spec     = 1'b1;
                        u_spec_res = zero_of(u_sp);
                    end else if (b_zero) begin
                        u_spec              = 1'b1;
                        u_spec_res          = inf_of(u_sp);
                        u_spec_flags[F_DBZ] = 1'b1;
                    end else if (a_zero) begin
                        u_spec     = 1'b1;
                        u_spec_res = zero_of(u_sp);
                    end
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Execute: aligned add/sub, full product, one restoring divide step
    // ------------------------------------------------------------------
    logic                 a_ge_b;
    logic [EXP_W-1:0]     big_e, small_e, exp_diff;
    logic [MAN_W:0]       big_m, small_m;
    logic                 big_s;
    logic [AW-1:0]        big_ext, small_ext, add_sum;
    logic [NW-1:0]        add_v, mul_v;
    logic                 div_ge;
    logic [QW-1:0]        rem_d, quo_d;
    logic signed [E2-1:0] exec_e;
    logic                 exec_s;

    // Datapath for the EXEC state
    always_comb begin
        a_ge_b    = {ea_q, ma_q} >= {eb_q, mb_q};
        big_e     = a_ge_b ? ea_q : eb_q;
        small_e   = a_ge_b ? eb_q : ea_q;
        big_m     = a_ge_b ? ma_q : mb_q;
        small_m   = a_ge_b ? mb_q : ma_q;
        big_s     = a_ge_b ? sa_q : sb_q;
        exp_diff  = big_e - small_e;
        big_ext   = {1'b0, big_m, 1'b0};
        // bits shifted past the guard are simply dropped
        small_ext = {1'b0, small_m, 1'b0} >> exp_diff;
        add_sum   = (sa_q != sb_q) ? big_ext - small_ext : big_ext + small_ext;
        // hidden-bit position lands on NW-2, carry on NW-1
        add_v     = NW'(add_sum) << (NW - AW);

        mul_v     = NW'(ma_q) * NW'(mb_q);

        div_ge    = rem_q >= QW'(mb_q);
        rem_d     = (div_ge ? rem_q - QW'(mb_q) : rem_q) << 1;
        quo_d     = {quo_q[QW-2:0], div_ge};

        unique case (op_q)
            OP_MUL: begin
                exec_e = E2'(ea_q) + E2'(eb_q) - BIAS;
                exec_s = sp_q;
            end
            OP_DIV: begin
                exec_e = E2'(ea_q) - E2'(eb_q) + BIAS;
                exec_s = sp_q;
            end
            default: begin
                exec_e = E2'(big_e);
                exec_s = big_s;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Normalise: leading-one detect, exponent adjust, truncate, pack
    // ------------------------------------------------------------------
    logic [NW-1:0]        norm_v;
    logic [LZ_W-1:0]      lz;
    logic signed [E2-1:0] norm_e;
    logic [MAN_W-1:0]     norm_frac;
    logic [W-1:0]         norm_res;
    logic [3:0]           norm_flags;

    // Value convention: leading one at NW-2 means exponent exp_q unchanged
    always_comb begin
        norm_v = (op_q == OP_DIV) ? (NW'(quo_q) << (NW - QW - 1)) : man_q;
        lz = '0;
        for (int i = 0; i < NW; i++) begin
            if (norm_v[i]) lz = LZ_W'(NW - 1 - i);
        end
        norm_e    = exp_q + E2'(1) - E2'(lz);
        norm_frac = MAN_W'((norm_v << lz) >> (NW - 1 - MAN_W));

        norm_res   = '0;
        norm_flags = '0;
        if (spec_q) begin
            norm_res   = spec_res_q;
            norm_flags = spec_flags_q;
        end else if (norm_v == '0) begin
            // exact zero sum: +0 unless both addends were -0
            norm_res = zero_of(sa_q & sb_q);
        end else if (norm_e >= EXP_MAX) begin
            norm_res          = inf_of(sign_q);
            norm_flags[F_OVF] = 1'b1;
        end else if (norm_e[E2-1] || (norm_e == '0)) begin
            norm_res          = zero_of(sign_q);
            norm_flags[F_UNF] = 1'b1;
        end else begin
            norm_res = {sign_q, norm_e[EXP_W-1:0], norm_frac};
        end
    end

    // ------------------------------------------------------------------
    // Control FSM with registered handshake outputs and datapath state
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            in_ready     <= 1'b1;
            out_valid    <= 1'b0;
            result       <= '0;
            flags        <= '0;
            a_q          <= '0;
            b_q          <= '0;
            op_q         <= OP_ADD;
            sa_q         <= 1'b0;
            sb_q         <= 1'b0;
            sp_q         <= 1'b0;
            ea_q         <= '0;
            eb_q         <= '0;
            ma_q         <= '0;
            mb_q         <= '0;
            spec_q       <= 1'b0;
            spec_res_q   <= '0;
            spec_flags_q <= '0;
            man_q        <= '0;
            exp_q        <= '0;
            sign_q       <= 1'b0;
            rem_q        <= '0;
            quo_q        <= '0;
            cnt_q        <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid && in_ready) begin
                        a_q      <= a;
                        b_q      <= b;
                        op_q     <= op;
                        in_ready <= 1'b0;
                        state_q  <= StUnpack;
                    end
                end
                StUnpack: begin
                    sa_q         <= u_sa;
                    sb_q         <= u_sb;
                    sp_q         <= u_sp;
                    ea_q         <= a_exp;
                    eb_q         <= b_exp;
                    ma_q         <= u_ma;
                    mb_q         <= u_mb;
                    spec_q       <= u_spec;
                    spec_res_q   <= u_spec_res;
                    spec_flags_q <= u_spec_flags;
                    rem_q        <= QW'(u_ma);
                    quo_q        <= '0;
                    cnt_q        <= '0;
                    state_q      <= StExec;
                end
                StExec: begin
                    exp_q  <= exec_e;
                    sign_q <= exec_s;
                    if (op_q == OP_DIV) begin
                        // specials still iterate so latency stays fixed per op
                        rem_q <= rem_d;
                        quo_q <= quo_d;
                        cnt_q <= cnt_q + CNT_W'(1);
                        if (cnt_q == CNT_W'(QW - 1)) state_q <= StNorm;
                    end else begin
                        man_q   <= (op_q == OP_MUL) ? mul_v : add_v;
                        state_q <= StNorm;
                    end
                end
                StNorm: begin
                    result    <= norm_res;
                    flags     <= norm_flags;
                    out_valid <= 1'b1;
                    state_q   <= StDone;
                end
                StDone: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        flags     <= '0;
                        in_ready  <= 1'b1;
                        state_q   <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_falu_seq.sv
// tb_falu_seq: directed vectors for falu_seq at the 16-bit default format.
module tb_falu_seq;

    localparam int unsigned EXP_W = 5;
    localparam int unsigned MAN_W = 10;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic [1:0]  op = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] result;
    logic [3:0]  flags;

    int n_checks = 0;
    int n_errors = 0;

    falu_seq #(
        .EXP_W(EXP_W),
        .MAN_W(MAN_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .op       (op),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .result   (result),
        .flags    (flags)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one op with out_ready=1; check latency, result, flags and handshake.
    task automatic run_op(input string tag, input logic [15:0] ta, input logic [15:0] tb,
                          input logic [1:0] top, input logic [15:0] er, input logic [3:0] ef,
                          input int elat);
        int guard;
        int lat;
        guard = 0;
        while (!in_ready && guard < 40) begin
            tick();
            guard++;
        end
        check({tag, " in_ready"}, 32'(in_ready), 32'd1);
        a        = ta;
        b        = tb;
        op       = top;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        a        = 16'h5555;
        b        = 16'hAAAA;
        op       = ~top;
        check({tag, " busy"}, 32'(in_ready), 32'd0);
        lat = 0;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
        check({tag, " lat"}, 32'(lat), 32'(elat));
        check({tag, " res"}, 32'(result), 32'(er));
        check({tag, " flags"}, 32'(flags), 32'(ef));
        tick();
        check({tag, " post"}, {26'd0, out_valid, in_ready, flags}, 32'b010000);
    endtask

    initial begin
        int lat;
        int ov_seen;

        rst_n = 1'b0;
        tick();
        tick();
        check("reset", {10'd0, in_ready, out_valid, flags, result}, {10'd0, 1'b1, 1'b0, 4'h0, 16'h0});
        rst_n = 1'b1;
        tick();

        run_op("add 1+2",       16'h3C00, 16'h4000, 2'b00, 16'h4200, 4'b0000, 3);
        run_op("sub 3-1",       16'h4200, 16'h3C00, 2'b01, 16'h4000, 4'b0000, 3);
        run_op("mul 2*3",       16'h4000, 16'h4200, 2'b10, 16'h4600, 4'b0000, 3);
        run_op("add 1-1",       16'h3C00, 16'hBC00, 2'b00, 16'h0000, 4'b0000, 3);
        run_op("div 1/3",       16'h3C00, 16'h4200, 2'b11, 16'h3555, 4'b0000, 14);
        run_op("div 1/0",       16'h3C00, 16'h0000, 2'b11, 16'h7C00, 4'b0100, 14);
        run_op("sub inf-inf",   16'h7C00, 16'h7C00, 2'b01, 16'h7E00, 4'b1000, 3);
        run_op("mul ovf",       16'h7BFF, 16'h4000, 2'b10, 16'h7C00, 4'b0010, 3);
        run_op("mul unf",       16'h0400, 16'h0400, 2'b10, 16'h0000, 4'b0001, 3);
        run_op("sub 1-2",       16'h3C00, 16'h4000, 2'b01, 16'hBC00, 4'b0000, 3);
        run_op("mul -2*1.5",    16'hC000, 16'h3E00, 2'b10, 16'hC200, 4'b0000, 3);
        run_op("div 3/1",       16'h4200, 16'h3C00, 2'b11, 16'h4200, 4'b0000, 14);
        run_op("add -0+-0",     16'h8000, 16'h8000, 2'b00, 16'h8000, 4'b0000, 3);
        run_op("mul 0*inf",     16'h0000, 16'h7C00, 2'b10, 16'h7E00, 4'b1000, 3);
        run_op("add snan",      16'h7C01, 16'h3C00, 2'b00, 16'h7E00, 4'b1000, 3);
        run_op("mul qnan",      16'h7E01, 16'h3C00, 2'b10, 16'h7E00, 4'b0000, 3);
        run_op("div -1/inf",    16'hBC00, 16'h7C00, 2'b11, 16'h8000, 4'b0000, 14);
        run_op("div 0/0",       16'h0000, 16'h0000, 2'b11, 16'h7E00, 4'b1000, 14);
        run_op("add -inf+1",    16'hFC00, 16'h3C00, 2'b00, 16'hFC00, 4'b0000, 3);
        run_op("mul subnorm",   16'h0001, 16'h3C00, 2'b10, 16'h0000, 4'b0000, 3);
        run_op("add 1+0",       16'h3C00, 16'h0000, 2'b00, 16'h3C00, 4'b0000, 3);
        run_op("sub unf",       16'h0600, 16'h0400, 2'b01, 16'h0000, 4'b0001, 3);
        run_op("add ovf",       16'h7BFF, 16'h7BFF, 2'b00, 16'h7C00, 4'b0010, 3);

        // Backpressure: result held in DONE, new request refused until handshake
        out_ready = 1'b0;
        check("bp idle", 32'(in_ready), 32'd1);
        a        = 16'h4000;
        b        = 16'h4200;
        op       = 2'b10;
        in_valid = 1'b1;
        tick();
        a  = 16'h3C00;
        b  = 16'h3C00;
        op = 2'b00;
        lat = 0;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
        check("bp lat", 32'(lat), 32'd3);
        for (int i = 0; i < 5; i++) begin
            check("bp hold", {10'd0, out_valid, in_ready, flags, result},
                  {10'd0, 1'b1, 1'b0, 4'h0, 16'h4600});
            tick();
        end
        out_ready = 1'b1;
        tick();
        check("bp release", {30'd0, out_valid, in_ready}, 32'b01);
        tick();
        in_valid = 1'b0;
        check("bp accept", 32'(in_ready), 32'd0);
        lat = 0;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
        check("bp2 lat", 32'(lat), 32'd3);
        check("bp2 res", 32'(result), 32'h4000);
        tick();

        // Reset in the middle of a division
        check("rdiv idle", 32'(in_ready), 32'd1);
        a        = 16'h3C00;
        b        = 16'h4200;
        op       = 2'b11;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (5) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("rdiv reset", {10'd0, out_valid, in_ready, flags, result},
              {10'd0, 1'b0, 1'b1, 4'h0, 16'h0});
        ov_seen = 0;
        for (int i = 0; i < 15; i++) begin
            if (out_valid) ov_seen++;
            tick();
        end
        check("rdiv no out", 32'(ov_seen), 32'd0);
        run_op("after rst", 16'h3C00, 16'h3C00, 2'b00, 16'h4000, 4'b0000, 3);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
